// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch unit
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [FETCH_ADDR_W-1:0] DEFAULT_PC_STEP  = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FULL  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch queue FIFO with flush; extra pointer MSB separates full from empty
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_wr;
  logic         w_rd;

  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_empty = (r_wr == r_rd);
  assign o_count = r_wr - r_rd;
  assign o_data  = r_mem[r_rd[AW-1:0]];
  assign w_wr    = i_push && !i_flush && !o_full;
  assign w_rd    = i_pop && !i_flush && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - credit-limited instruction fetch with redirect flush
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                FQ_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [ADDR_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e             r_state;
  fetch_state_e             w_state_next;
  logic [ADDR_W-1:0]        r_pc;
  logic                     r_inflight;
  logic [ADDR_W-1:0]        r_inflight_pc;
  logic                     w_issue;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [CW-1:0]            w_count;
  logic [CW-1:0]            w_count_next;
  logic [CW-1:0]            w_occ_next;
  logic [ADDR_W+DATA_W-1:0] w_head;

  // Redirect voids any handshake and the response landing in the same cycle.
  assign w_pop  = !w_empty && out_ready && !redirect_valid;
  assign w_push = r_inflight && (r_state != ST_FLUSH) && !redirect_valid;

  always_comb begin
    w_issue      = !redirect_valid && (r_state != ST_FULL);
    w_state_next = ST_FLUSH;
    w_count_next = '0;
    w_occ_next   = '0;
    if (!redirect_valid) begin
      w_count_next = w_count + CW'(w_push) - CW'(w_pop);
      w_occ_next   = w_count_next + CW'(w_issue);
      w_state_next = (w_occ_next == CW'(FQ_DEPTH)) ? ST_FULL : ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + PC_STEP;
      end
      if (redirect_valid) r_pc <= redirect_pc;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .W     (ADDR_W + DATA_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_inflight_pc, imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign imem_req  = w_issue && !rst && !w_full;
  assign imem_addr = r_pc;
  assign out_valid = !w_empty;
  assign out_pc    = w_empty ? '0 : w_head[ADDR_W+DATA_W-1:DATA_W];
  assign out_instr = w_empty ? '0 : w_head[DATA_W-1:0];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (w_pop) perf_fetched <= sat_add32(perf_fetched, 32'd1);
      if (redirect_valid)
        perf_flushed <= sat_add32(perf_flushed, 32'(w_count) + 32'(r_inflight));
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - bench for instr_fetch_unit: in-order pc scoreboard plus directed scenarios
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2 = '0;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [31:0] out_instr2;
  logic [31:0] out_pc2;
  logic [31:0] perf_fetched2;
  logic [31:0] perf_flushed2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata  <= imem_addr << 4;
    imem_rdata2 <= imem_addr2 << 4;
  end

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .out_valid      (out_valid2),
    .out_ready      (out_ready2),
    .out_instr      (out_instr2),
    .out_pc         (out_pc2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched2),
    .perf_flushed   (perf_flushed2)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: program order is RESET_PC, +1, +1 ... restarting at each redirect target;
  // requests outstanding (issued but not delivered) may never exceed the queue depth.
  logic [31:0] m_exp_pc, m_req_pc, m_fetched, m_flushed, m_hold_pc, m_hold_instr;
  int          m_out;
  bit          m_after_redir, m_hold;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_imem_req", imem_req, 0);
      m_exp_pc = 0; m_req_pc = 0; m_out = 0; m_fetched = 0; m_flushed = 0;
      m_after_redir = 0; m_hold = 0;
    end else begin
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_flushed", perf_flushed, m_flushed);
`endif
      if (m_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_pc", out_pc, m_hold_pc);
        check("hold_instr", out_instr, m_hold_instr);
      end
      if (m_after_redir) check("post_redirect_valid", out_valid, 0);
      if (redirect_valid) begin
        check("redirect_no_req", imem_req, 0);
        m_flushed += m_out;
        m_exp_pc = redirect_pc; m_req_pc = redirect_pc; m_out = 0;
        m_after_redir = 1; m_hold = 0;
      end else begin
        m_after_redir = 0;
        if (imem_req) begin
          check("req_addr", imem_addr, m_req_pc);
          check("req_credit", m_out < 4, 1);
          m_req_pc += 1; m_out++;
        end
        if (out_valid && out_ready) begin
          check("out_pc", out_pc, m_exp_pc);
          check("out_instr", out_instr, m_exp_pc << 4);
          m_exp_pc += 1; m_out--; m_fetched++;
        end
        m_hold = out_valid && !out_ready;
        m_hold_pc = out_pc; m_hold_instr = out_instr;
      end
    end
  end

  task automatic do_reset(input logic rdy);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = rdy; redirect_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid_pc(input string name, input logic [31:0] exp_pc);
    bit found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    check({name, "_seen"}, found, 1);
    if (found) check({name, "_pc"}, out_pc, exp_pc);
  endtask

  initial begin
    int          n_req;
    logic [31:0] f0;
    logic [31:0] pat;
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_req;
    logic [31:0] f0;
    logic [31:0] pat;
    pat = 32'hB3C5_0F69;
    f0  = '0;
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    check("reset_imem_addr", imem_addr, 32'h0);
    check("reset_out_pc", out_pc, 32'h0);
    check("reset_out_instr", out_instr, 32'h0);
    check("reset_imem_addr_wrap", imem_addr2, 32'hFFFF_FFFE);

    // Fill latency and steady stream; second instance exercises pc wrap.
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("c0_req", imem_req, 1); check("c0_addr", imem_addr, 0); check("c0_valid", out_valid, 0);
    @(negedge clk);
    check("c1_valid", out_valid, 0);
    @(negedge clk);
    check("c2_valid", out_valid, 1); check("c2_pc", out_pc, 0); check("c2_instr", out_instr, 32'h0);
    check("wrap_pc0", out_pc2, 32'hFFFF_FFFE);
    @(negedge clk);
    check("c3_pc", out_pc, 1); check("c3_instr", out_instr, 32'h10);
    check("wrap_pc1", out_pc2, 32'hFFFF_FFFF);
    @(negedge clk);
    check("c4_pc", out_pc, 2); check("c4_instr", out_instr, 32'h20);
    check("wrap_pc2", out_pc2, 32'h0);
    repeat (5) @(negedge clk);

    // Backpressure: exactly four requests fill the queue, then drain without gaps.
    do_reset(1'b0);
    n_req = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req) n_req++;
    end
    check("full_req_count", n_req, 4);
    check("full_valid", out_valid, 1);
    check("full_head_pc", out_pc, 0);
    check("full_no_req", imem_req, 0);
    @(posedge clk); #1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_valid", out_valid, 1);
      check("drain_pc", out_pc, i);
    end

    // Redirect with three queued and one in flight.
    do_reset(1'b0);
    repeat (4) @(posedge clk);
    #1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    check("pre_redir_head", out_pc, 0);
    @(posedge clk); #1; redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("r29_valid0", out_valid, 0); check("r29_req", imem_req, 1); check("r29_addr", imem_addr, 32'h100);
    @(negedge clk);
    check("r29_valid1", out_valid, 0);
    @(negedge clk);
    check("r29_valid2", out_valid, 1); check("r29_pc", out_pc, 32'h100); check("r29_instr", out_instr, 32'h1000);
`ifdef FETCH_PERF_CNT_EN
    check("r29_flushed", perf_flushed, 4);
`endif

    // Redirect coinciding with a handshake.
    repeat (3) @(posedge clk);
    #1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    check("r30_valid", out_valid, 1);
`ifdef FETCH_PERF_CNT_EN
    f0 = perf_fetched;
`endif
    @(posedge clk); #1; redirect_valid = 1'b0;
    @(negedge clk);
    check("r30_valid_drop", out_valid, 0);
`ifdef FETCH_PERF_CNT_EN
    check("r30_fetched_void", perf_fetched, f0);
`endif
    wait_valid_pc("r30_next", 32'h200);

    // Asynchronous reset with a full queue.
    @(posedge clk); #1; out_ready = 1'b0;
    repeat (8) @(negedge clk);
    check("r32_full_valid", out_valid, 1);
    @(posedge clk); #2; rst = 1'b1;
    #1;
    check("r32_async_valid", out_valid, 0);
    check("r32_async_req", imem_req, 0);
    @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
    wait_valid_pc("r32_first", 32'h0);

    // Irregular backpressure with one redirect; the scoreboard checks every cycle.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      out_ready      = pat[i % 32];
      redirect_valid = (i == 20);
      redirect_pc    = 32'h300;
    end
    @(posedge clk); #1; redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, 32, PC width in bits.
REQ-002 DATA_W, 32, instruction width in bits.
REQ-003 FQ_DEPTH, 4, fetch-queue entries; power of two, 2..16.
REQ-004 RESET_PC, 0, PC loaded on reset.
REQ-005 PC_STEP, 1, PC increment per sequential fetch (word addressing).
REQ-006 The block SHALL have these ports, one per line, as name, direction, width, meaning:
  clk  in  1  single clock, rising edge.
  rst  in  1  reset; asynchronous, active-high.
  imem_req  out  1  instruction-memory read strobe.
  imem_addr  out  ADDR_W  read address.
  imem_rdata  in  DATA_W  read data, valid exactly 1 cycle after imem_req.
  redirect_valid  in  1  branch/jump redirect from a later stage.
  redirect_pc  in  ADDR_W  redirect target.
  out_valid  out  1  queue head valid to decode.
  out_ready  in  1  decode accepts head.
  out_instr  out  DATA_W  head instruction.
  out_pc  out  ADDR_W  address of head instruction.

Function
REQ-007 Transfer to decode SHALL occur on any cycle where out_valid and out_ready are both high; the head is popped on that edge.
REQ-008 out_valid, out_instr and out_pc SHALL be stable while out_valid=1 and out_ready=0.
REQ-009 A request SHALL issue (imem_req=1, imem_addr=pc, pc += PC_STEP) only if queue occupancy + in-flight requests < FQ_DEPTH and redirect_valid=0.
REQ-010 Each response SHALL be written to the queue tail with its request address, in request order.
REQ-011 A simultaneous pop and push SHALL both occur; occupancy stays unchanged.
REQ-012 A push into an empty queue SHALL raise out_valid on the next cycle (no bypass).
REQ-013 With out_ready held high, throughput SHALL be one instruction per cycle after fill.
REQ-014 On redirect_valid=1: flush the queue, set out_valid=0 next cycle, discard the response of any request issued in the previous cycle, and set pc to redirect_pc; no imem_req that cycle.
REQ-015 Redirect SHALL take priority over simultaneous pop, push and issue; a handshake in the redirect cycle is void.
REQ-016 The first request after redirect SHALL issue in the following cycle at redirect_pc.
REQ-017 The FSM SHALL have states RUN (issuing allowed), FULL (occupancy + in-flight = FQ_DEPTH, no issue) and FLUSH (one cycle after redirect, drop in-flight response); transitions RUN<->FULL on credit, any->FLUSH on redirect, FLUSH->RUN unconditionally.
REQ-018 PC arithmetic SHALL wrap modulo 2^ADDR_W without error.
REQ-019 Queue read/write pointers SHALL be log2(FQ_DEPTH)+1 bits, with full/empty distinguished by the MSB.

Reset
REQ-020 On rst: pc=RESET_PC, queue empty, state=RUN, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, in-flight cleared, counters=0.
REQ-021 Assertion of rst mid-operation SHALL discard queue contents and in-flight responses immediately.
REQ-022 The first imem_req SHALL occur in the first cycle after rst deasserts.

Configuration
REQ-023 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs perf_fetched (32, incremented per accepted handshake) and perf_flushed (32, incremented by the number of queued plus discarded in-flight entries at each redirect), both saturating at all-ones.
REQ-024 Without FETCH_PERF_CNT_EN, these ports and counters SHALL be absent, with no change to other behaviour.

Structure
REQ-025 A shared package fetch_pkg SHALL hold the FSM state enum, the queue entry typedef {pc, instr}, and the defaults for RESET_PC and PC_STEP.
REQ-026 The queue SHALL be a sub-module fetch_queue (parameters DEPTH and entry width, with push/pop/flush, full/empty and count).

Verification
REQ-027 Reset release, out_ready=1, imem returns addr*16: out_pc 0,1,2,3... with out_instr 0x0,0x10,0x20, first out_valid 2 cycles after first imem_req, then 1/cycle.
REQ-028 out_ready=0 for 10 cycles: exactly 4 entries queued, imem_req low while FULL, head pc=0 held stable; release -> pcs 0..3 then 4 with no gap or duplicate.
REQ-029 Redirect to 0x100 while 3 queued and 1 in flight: out_valid=0 next cycle; next valid out_pc=0x100; stale pcs never appear; perf_flushed += 4 when FETCH_PERF_CNT_EN is defined.
REQ-030 Redirect coincident with out_valid&&out_ready: the popped entry is not counted in perf_fetched and the next out_pc equals the redirect target.
REQ-031 RESET_PC=0xFFFFFFFE, PC_STEP=1: out_pc sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
REQ-032 rst pulsed mid-stream with a full queue: out_valid=0 immediately, and the first post-reset out_pc equals RESET_PC.
